// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and hazard sequencing controller for the 5-stage pipeline.
// Optional cycle statistics counters are enabled by defining HAZARD_STATS_EN.
module fwd_hazard_ctrl #(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned BR_PENALTY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              ex_branch_taken,
    input  logic              mem_wait,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              pc_write_en,
    output logic              ifid_write_en,
    output logic              pipe_freeze,
    output logic              flush_ifid,
    output logic              flush_idex
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt,
    output logic [31:0]       freeze_cnt
`endif
);

    localparam int unsigned CNT_W = 2;
    localparam logic [CNT_W-1:0] BR_RELOAD = CNT_W'(BR_PENALTY - 1);

    logic              idex_valid, idex_regwrite, idex_memread;
    logic [REG_AW-1:0] idex_rs1, idex_rs2, idex_rd;
    logic              exmem_valid, exmem_regwrite;
    logic [REG_AW-1:0] exmem_rd;
    logic              memwb_valid, memwb_regwrite;
    logic [REG_AW-1:0] memwb_rd;
    logic [CNT_W-1:0]  flush_ctr;

    logic exmem_src_ok, memwb_src_ok, load_use, advance, stall_now, branch_now;

    assign exmem_src_ok = exmem_valid && exmem_regwrite && (exmem_rd != '0);
    assign memwb_src_ok = memwb_valid && memwb_regwrite && (memwb_rd != '0);

    assign load_use = idex_valid && idex_memread && (idex_rd != '0) && id_valid &&
                      ((idex_rd == id_rs1) || (idex_rd == id_rs2));

    // Shadow state only moves on edges where the pipeline itself moves.
    assign advance    = !reset && !mem_wait;
    assign branch_now = advance && ex_branch_taken;
    assign stall_now  = advance && !ex_branch_taken && load_use;

    // Operand selects: EX/MEM outranks MEM/WB; x0 never forwarded.
    always_comb begin
        forward_a = 2'b00;
        forward_b = 2'b00;
        if (exmem_src_ok && (exmem_rd == idex_rs1))      forward_a = 2'b10;
        else if (memwb_src_ok && (memwb_rd == idex_rs1)) forward_a = 2'b01;
        if (exmem_src_ok && (exmem_rd == idex_rs2))      forward_b = 2'b10;
        else if (memwb_src_ok && (memwb_rd == idex_rs2)) forward_b = 2'b01;
    end

    // Hazard controls: freeze beats branch, branch beats load-use.
    always_comb begin
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        pipe_freeze   = 1'b0;
        flush_ifid    = 1'b0;
        flush_idex    = 1'b0;
        if (reset) begin
            pc_write_en   = 1'b1;
        end else if (mem_wait) begin
            pipe_freeze   = 1'b1;
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
        end else if (ex_branch_taken) begin
            flush_ifid    = 1'b1;
            flush_idex    = 1'b1;
        end else begin
            flush_ifid = (flush_ctr != '0);
            if (load_use) begin
                pc_write_en   = 1'b0;
                ifid_write_en = 1'b0;
                flush_idex    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_valid     <= 1'b0;
            idex_regwrite  <= 1'b0;
            idex_memread   <= 1'b0;
            idex_rs1       <= '0;
            idex_rs2       <= '0;
            idex_rd        <= '0;
            exmem_valid    <= 1'b0;
            exmem_regwrite <= 1'b0;
            exmem_rd       <= '0;
            memwb_valid    <= 1'b0;
            memwb_regwrite <= 1'b0;
            memwb_rd       <= '0;
            flush_ctr      <= '0;
        end else if (advance) begin
            memwb_valid    <= exmem_valid;
            memwb_regwrite <= exmem_regwrite;
            memwb_rd       <= exmem_rd;
            exmem_valid    <= idex_valid;
            exmem_regwrite <= idex_regwrite;
            exmem_rd       <= idex_rd;
            idex_rs1       <= id_rs1;
            idex_rs2       <= id_rs2;
            idex_rd        <= id_rd;
            if (flush_idex) begin
                idex_valid    <= 1'b0;
                idex_regwrite <= 1'b0;
                idex_memread  <= 1'b0;
            end else begin
                idex_valid    <= id_valid;
                idex_regwrite <= id_regwrite;
                idex_memread  <= id_memread;
            end
            if (ex_branch_taken)     flush_ctr <= BR_RELOAD;
            else if (flush_ctr != '0) flush_ctr <= flush_ctr - CNT_W'(1);
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            if (stall_now)  stall_cnt  <= stall_cnt + 32'd1;
            if (branch_now) flush_cnt  <= flush_cnt + 32'd1;
            if (mem_wait)   freeze_cnt <= freeze_cnt + 32'd1;
        end
    end
`else
    logic unused_stats;
    assign unused_stats = stall_now ^ branch_now;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: forwarding, load-use, branch flush, freeze, reset.
module tb_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_regwrite, id_memread;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_branch_taken, mem_wait;
    logic [1:0] forward_a, forward_b;
    logic       pc_write_en, ifid_write_en, pipe_freeze, flush_ifid, flush_idex;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt, flush_cnt, freeze_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.REG_AW(5), .BR_PENALTY(2)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait),
        .forward_a(forward_a), .forward_b(forward_b),
        .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en),
        .pipe_freeze(pipe_freeze), .flush_ifid(flush_ifid), .flush_idex(flush_idex)
`ifdef HAZARD_STATS_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic rw, input logic mr);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_regwrite = rw; id_memread = mr;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic check_ctl(input string tag, input logic pc, input logic ifid,
                             input logic frz, input logic fif, input logic fid);
        check({tag, "_pc"},   32'(pc_write_en),   32'(pc));
        check({tag, "_ifid"}, 32'(ifid_write_en), 32'(ifid));
        check({tag, "_frz"},  32'(pipe_freeze),   32'(frz));
        check({tag, "_fif"},  32'(flush_ifid),    32'(fif));
        check({tag, "_fid"},  32'(flush_idex),    32'(fid));
    endtask

    initial begin
        reset = 1'b1; ex_branch_taken = 1'b0; mem_wait = 1'b0;
        nop();
        nxt(); nxt(); #1;
        check("rst_fa", 32'(forward_a), 32'd0);
        check("rst_fb", 32'(forward_b), 32'd0);
        check_ctl("rst", 1, 1, 0, 0, 0);
        nxt(); reset = 1'b0;

        // add x5,x1,x2 ; sub x6,x5,x3 ; or x7,x5,x5
        nxt(); set_id(1, 5'd1, 5'd2, 5'd5, 1, 0);
        nxt(); set_id(1, 5'd5, 5'd3, 5'd6, 1, 0);
        nxt(); set_id(1, 5'd5, 5'd5, 5'd7, 1, 0); #1;
        check("sub_fa", 32'(forward_a), 32'd2);
        check("sub_fb", 32'(forward_b), 32'd0);
        nxt(); nop(); #1;
        check("or_fa", 32'(forward_a), 32'd1);
        check("or_fb", 32'(forward_b), 32'd1);

        // x5 in both EX/MEM and MEM/WB; then an rd=x0 producer
        nxt(); set_id(1, 5'd0, 5'd0, 5'd5, 1, 0);
        nxt(); set_id(1, 5'd0, 5'd0, 5'd5, 1, 0);
        nxt(); set_id(1, 5'd5, 5'd7, 5'd9, 0, 0);
        nxt(); set_id(1, 5'd0, 5'd0, 5'd0, 1, 0); #1;
        check("prio_fa", 32'(forward_a), 32'd2);
        check("prio_fb", 32'(forward_b), 32'd0);
        nxt(); set_id(1, 5'd0, 5'd0, 5'd1, 1, 0);
        nxt(); nop(); #1;
        check("x0_fa", 32'(forward_a), 32'd0);
        check("x0_fb", 32'(forward_b), 32'd0);

        // ld x8 ; add x9,x8,x1
        repeat (3) begin nxt(); nop(); end
        nxt(); set_id(1, 5'd1, 5'd0, 5'd8, 1, 1); #1;
        check_ctl("ld_id", 1, 1, 0, 0, 0);
        nxt(); set_id(1, 5'd8, 5'd1, 5'd9, 1, 0); #1;
        check_ctl("lu_stall", 0, 0, 0, 0, 1);
        nxt(); #1;
        check_ctl("lu_after", 1, 1, 0, 0, 0);
        nxt(); nop(); #1;
        check("lu_fa", 32'(forward_a), 32'd1);
        check("lu_fb", 32'(forward_b), 32'd0);
`ifdef HAZARD_STATS_EN
        check("stall_cnt1", stall_cnt, 32'd1);
`endif

        // taken branch, penalty 2
        repeat (3) begin nxt(); nop(); end
        nxt(); ex_branch_taken = 1'b1; #1;
        check_ctl("br0", 1, 1, 0, 1, 1);
        nxt(); ex_branch_taken = 1'b0; #1;
        check_ctl("br1", 1, 1, 0, 1, 0);
        nxt(); #1;
        check_ctl("br2", 1, 1, 0, 0, 0);

        // branch coincident with load-use
        nxt(); set_id(1, 5'd2, 5'd0, 5'd10, 1, 1);
        nxt(); set_id(1, 5'd10, 5'd3, 5'd4, 1, 0); ex_branch_taken = 1'b1; #1;
        check_ctl("brlu0", 1, 1, 0, 1, 1);
        nxt(); ex_branch_taken = 1'b0; nop(); #1;
        check_ctl("brlu1", 1, 1, 0, 1, 0);
        nxt(); #1;
        check_ctl("brlu2", 1, 1, 0, 0, 0);
`ifdef HAZARD_STATS_EN
        check("flush_cnt", flush_cnt, 32'd2);
        check("stall_cnt_br", stall_cnt, 32'd1);
`endif

        // w x5 ; ld x11,0(x5) ; add x12,x11,x0 with 3-cycle mem_wait
        repeat (3) begin nxt(); nop(); end
        nxt(); set_id(1, 5'd0, 5'd0, 5'd5, 1, 0);
        nxt(); set_id(1, 5'd5, 5'd0, 5'd11, 1, 1);
        nxt(); set_id(1, 5'd11, 5'd0, 5'd12, 1, 0); mem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) nxt();
            #1;
            check_ctl("frz", 0, 0, 1, 0, 0);
            check("frz_fa", 32'(forward_a), 32'd2);
            check("frz_fb", 32'(forward_b), 32'd0);
        end
        nxt(); mem_wait = 1'b0; #1;
        check_ctl("frz_stall", 0, 0, 0, 0, 1);
        check("frz_stall_fa", 32'(forward_a), 32'd2);
        nxt(); #1;
        check_ctl("frz_after", 1, 1, 0, 0, 0);
        nxt(); nop(); #1;
        check("frz_use_fa", 32'(forward_a), 32'd1);
        check("frz_use_fb", 32'(forward_b), 32'd0);
`ifdef HAZARD_STATS_EN
        check("freeze_cnt", freeze_cnt, 32'd3);
        check("stall_cnt2", stall_cnt, 32'd2);
`endif

        // reset with all stages valid
        nxt(); set_id(1, 5'd0, 5'd0, 5'd5, 1, 0);
        nxt(); set_id(1, 5'd0, 5'd0, 5'd5, 1, 0);
        nxt(); set_id(1, 5'd5, 5'd5, 5'd6, 0, 0);
        nxt(); nop(); #1;
        check("pre_rst_fa", 32'(forward_a), 32'd2);
        check("pre_rst_fb", 32'(forward_b), 32'd2);
        reset = 1'b1; ex_branch_taken = 1'b1; mem_wait = 1'b1; #1;
        check("in_rst_fa", 32'(forward_a), 32'd0);
        check("in_rst_fb", 32'(forward_b), 32'd0);
        check_ctl("in_rst", 1, 1, 0, 0, 0);
        nxt(); reset = 1'b0; ex_branch_taken = 1'b0; mem_wait = 1'b0; #1;
        check("post_rst_fa", 32'(forward_a), 32'd0);
        check("post_rst_fb", 32'(forward_b), 32'd0);
        check_ctl("post_rst", 1, 1, 0, 0, 0);
`ifdef HAZARD_STATS_EN
        check("rst_stall_cnt", stall_cnt, 32'd0);
        check("rst_freeze_cnt", freeze_cnt, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
